// File: rtl/dmem_port_arbiter_if.sv
// Bundle of requester, response and memory-port signals shared by the data-memory arbiter.
// slave is the arbiter's view; master is the requesters/memory view.
interface dmem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  uart_mode;
    logic                  uart_req;
    logic [ADDR_WIDTH-1:0] uart_addr;
    logic [DATA_WIDTH-1:0] uart_wdata;
    logic                  uart_ack;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_rvalid;
    logic                  cpu_stall;
    logic                  vga_req;
    logic [ADDR_WIDTH-1:0] vga_addr;
    logic [DATA_WIDTH-1:0] vga_rdata;
    logic                  vga_valid;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [1:0]            owner;

    modport slave (
        input  uart_mode, uart_req, uart_addr, uart_wdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vga_req, vga_addr, mem_rdata,
        output uart_ack, cpu_rdata, cpu_rvalid, cpu_stall,
        output vga_rdata, vga_valid,
        output mem_en, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output uart_mode, uart_req, uart_addr, uart_wdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vga_req, vga_addr, mem_rdata,
        input  uart_ack, cpu_rdata, cpu_rvalid, cpu_stall,
        input  vga_rdata, vga_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory arbiter for UART programmer, CPU MEM stage and VGA reader.
// One access per cycle; read data is steered back by a registered tag; VGA starvation is bounded.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int VGA_MAX_WAIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_VGA  = 2'b10,
        GNT_UART = 2'b11
    } grant_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_CPU  = 2'b01,
        TAG_VGA  = 2'b10
    } tag_e;

    localparam logic [3:0] MAX_WAIT = 4'(VGA_MAX_WAIT);

    grant_e                winner_s;
    grant_e                owner_r;
    tag_e                  rd_tag_s;
    tag_e                  rd_tag_r;
    logic [3:0]            wait_cnt_s;
    logic [3:0]            wait_cnt_r;
    logic                  cpu_rd_wait_s;
    logic                  cpu_rd_wait_r;
    logic                  cpu_stall_s;
    logic                  mem_en_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    // Winner selection; reset forces the port idle immediately.
    always_comb begin
        winner_s = GNT_NONE;
        if (!rst_n) begin
            winner_s = GNT_NONE;
        end else if (bus.uart_mode) begin
            if (bus.uart_req) begin
                winner_s = GNT_UART;
            end else begin
                winner_s = GNT_NONE;
            end
        end else if (bus.vga_req && (wait_cnt_r == MAX_WAIT)) begin
            winner_s = GNT_VGA;
        end else if (bus.cpu_req && !cpu_rd_wait_r) begin
            winner_s = GNT_CPU;
        end else if (bus.vga_req) begin
            winner_s = GNT_VGA;
        end else begin
            winner_s = GNT_NONE;
        end
    end

    // Memory port mux driven from the winner.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_WIDTH{1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        case (winner_s)
            GNT_CPU: begin
                mem_en_s    = 1'b1;
                mem_we_s    = bus.cpu_we;
                mem_addr_s  = bus.cpu_addr;
                mem_wdata_s = bus.cpu_wdata;
            end
            GNT_VGA: begin
                mem_en_s   = 1'b1;
                mem_addr_s = bus.vga_addr;
            end
            GNT_UART: begin
                mem_en_s    = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = bus.uart_addr;
                mem_wdata_s = bus.uart_wdata;
            end
            default: begin
                mem_en_s = 1'b0;
            end
        endcase
    end

    // CPU stall, next read tag and VGA wait counter.
    always_comb begin
        cpu_stall_s   = 1'b0;
        rd_tag_s      = TAG_NONE;
        cpu_rd_wait_s = 1'b0;
        wait_cnt_s    = wait_cnt_r;

        // The load-return cycle always releases the CPU, even if UART took over meanwhile.
        if (cpu_rd_wait_r) begin
            cpu_stall_s = 1'b0;
        end else if (winner_s == GNT_CPU) begin
            cpu_stall_s = ~bus.cpu_we;
        end else begin
            cpu_stall_s = bus.cpu_req;
        end

        if ((winner_s == GNT_CPU) && !bus.cpu_we) begin
            rd_tag_s      = TAG_CPU;
            cpu_rd_wait_s = 1'b1;
        end else if (winner_s == GNT_VGA) begin
            rd_tag_s = TAG_VGA;
        end else begin
            rd_tag_s = TAG_NONE;
        end

        if (!bus.vga_req || (winner_s == GNT_VGA)) begin
            wait_cnt_s = 4'd0;
        end else if (bus.uart_mode) begin
            wait_cnt_s = wait_cnt_r;
        end else if (wait_cnt_r >= MAX_WAIT) begin
            wait_cnt_s = MAX_WAIT;
        end else begin
            wait_cnt_s = wait_cnt_r + 4'd1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r       <= GNT_NONE;
            rd_tag_r      <= TAG_NONE;
            wait_cnt_r    <= 4'd0;
            cpu_rd_wait_r <= 1'b0;
        end else begin
            owner_r       <= winner_s;
            rd_tag_r      <= rd_tag_s;
            wait_cnt_r    <= wait_cnt_s;
            cpu_rd_wait_r <= cpu_rd_wait_s;
        end
    end

    assign bus.mem_en     = mem_en_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.uart_ack   = (winner_s == GNT_UART);
    assign bus.cpu_stall  = cpu_stall_s;
    assign bus.cpu_rvalid = cpu_rd_wait_r;
    assign bus.cpu_rdata  = (rd_tag_r == TAG_CPU) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    assign bus.vga_valid  = (rd_tag_r == TAG_VGA);
    assign bus.vga_rdata  = (rd_tag_r == TAG_VGA) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    assign bus.owner      = owner_r;
endmodule
